csa_resolve_32: RTL and testbench



---
 rtl/csa_resolve_32.sv | 129 ++++++++++++
 tb/tb_csa_resolve_32.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_32.sv
// Carry-save resolver: turns a (sum, carry<<1) pair into a 34-bit binary total over a 2-stage split adder.
// Define CSA_RESOLVE_FOLD_EN to add a third stage producing the 16-bit ones-complement fold of the total.
module csa_resolve_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_sum,
  input  logic [31:0] in_carry,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [1:0]  out_hi,
  output logic        out_last,
  output logic [15:0] out_fold
);

  logic [32:0] b_op;
  assign b_op = {in_carry, 1'b0};

  logic        s1_valid;
  logic [16:0] s1_lo;
  logic [15:0] s1_sa;
  logic [16:0] s1_sb;
  logic        s1_last;

  logic        s2_valid;
  logic [31:0] s2_result;
  logic [1:0]  s2_hi;
  logic        s2_last;

  logic        s1_en;
  logic        s2_en;
  logic [17:0] hi_sum;

  // upper half: 16-bit sum word + 17-bit shifted carry + low-half carry; peaks at 0x2FFFF
  assign hi_sum = {2'b00, s1_sa} + {1'b0, s1_sb} + {17'd0, s1_lo[16]};

`ifdef CSA_RESOLVE_FOLD_EN
  logic        s3_en;
  logic        s3_valid;
  logic [31:0] s3_result;
  logic [1:0]  s3_hi;
  logic        s3_last;
  logic [15:0] s3_fold;
  logic [17:0] f1;
  logic [16:0] f2;
  logic [15:0] f3;

  assign s3_en = !s3_valid | out_ready;
  assign s2_en = !s2_valid | s3_en;

  // two end-around folds suffice: f2 can only overflow when its low half is tiny
  assign f1 = {2'b00, s2_result[15:0]} + {2'b00, s2_result[31:16]} + {16'd0, s2_hi};
  assign f2 = {1'b0, f1[15:0]} + {15'd0, f1[17:16]};
  assign f3 = f2[15:0] + {15'd0, f2[16]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid  <= 1'b0;
      s3_result <= '0;
      s3_hi     <= '0;
      s3_last   <= 1'b0;
      s3_fold   <= '0;
    end else if (s3_en) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_result <= s2_result;
        s3_hi     <= s2_hi;
        s3_last   <= s2_last;
        s3_fold   <= f3;
      end
    end
  end

  assign out_valid  = s3_valid;
  assign out_result = s3_result;
  assign out_hi     = s3_hi;
  assign out_last   = s3_last;
  assign out_fold   = s3_fold;
`else
  assign s2_en = !s2_valid | out_ready;

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_hi     = s2_hi;
  assign out_last   = s2_last;
  assign out_fold   = '0;
`endif

  assign s1_en    = !s1_valid | s2_en;
  assign in_ready = s1_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_sa    <= '0;
      s1_sb    <= '0;
      s1_last  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo   <= {1'b0, in_sum[15:0]} + {1'b0, b_op[15:0]};
        s1_sa   <= in_sum[31:16];
        s1_sb   <= b_op[32:16];
        s1_last <= in_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_hi     <= '0;
      s2_last   <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= {hi_sum[15:0], s1_lo[15:0]};
        s2_hi     <= hi_sum[17:16];
        s2_last   <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_csa_resolve_32.sv
// Self-checking bench for csa_resolve_32: directed cases plus random traffic against a queue-based arithmetic model.
module tb_csa_resolve_32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic [31:0] in_carry;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_hi;
  logic        out_last;
  logic [15:0] out_fold;

`ifdef CSA_RESOLVE_FOLD_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  csa_resolve_32 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_hi(out_hi), .out_last(out_last), .out_fold(out_fold)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_lat = 1'b0;
  bit fin;
  bit fout;
  logic [33:0] exp_q[$];
  bit          last_q[$];
  int          acc_q[$];

  function automatic logic [33:0] total(logic [31:0] s, logic [31:0] c);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  function automatic logic [15:0] fold(logic [33:0] t);
    logic [33:0] v;
    v = t;
    while ((v >> 16) != 0) v = (v & 34'h0FFFF) + (v >> 16);
    return v[15:0];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: sample handshakes at negedge, score outputs, then resume 1ns after posedge
  task automatic cycle();
    logic [33:0] t;
    int a;
    @(negedge clk);
    cyc++;
    fin  = in_valid & in_ready;
    fout = out_valid & out_ready;
    if (!rst_n) begin
      exp_q.delete(); last_q.delete(); acc_q.delete();
      fin = 1'b0; fout = 1'b0;
    end else begin
      if (fout) begin
        if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
        else begin
          t = exp_q.pop_front();
          a = acc_q.pop_front();
          check("result", 64'(out_result), 64'(t[31:0]));
          check("hi", 64'(out_hi), 64'(t[33:32]));
          check("last", 64'(out_last), 64'(last_q.pop_front()));
`ifdef CSA_RESOLVE_FOLD_EN
          check("fold", 64'(out_fold), 64'(fold(t)));
`else
          check("fold_zero", 64'(out_fold), 64'd0);
`endif
          if (chk_lat) check("latency", 64'(cyc - a), 64'(LAT));
        end
      end
      if (fin) begin
        exp_q.push_back(total(in_sum, in_carry));
        last_q.push_back(in_last);
        acc_q.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] s, logic [31:0] c, bit l);
    in_valid = v; in_sum = s; in_carry = c; in_last = l;
  endtask

  task automatic drain(int budget);
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    int j;
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    cycle(); cycle();
    rst_n = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_hi", 64'(out_hi), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_fold", 64'(out_fold), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // single beats: low-half carry crossing, and maximum total
    chk_lat = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0);
    repeat (LAT + 1) cycle();
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); cycle();
    drive(1'b0, '0, '0, 1'b0);
    repeat (LAT) cycle();
    check("max_hi", 64'(out_hi), 64'd2);
    check("max_result", 64'(out_result), 64'hFFFF_FFFD);
    drain(10);

    // back-to-back stream with last on the 8th beat
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 32'(i), i == 7);
      cycle();
      check("b2b_accept", 64'(fin), 64'd1);
    end
    drain(10);
    chk_lat = 1'b0;

    // backpressure: 4 beats offered against a stalled sink
    out_ready = 1'b0; j = 0; held = '0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h1000 + 32'(j), 32'h0100_0000 * 32'(j + 1), 1'b0);
      cycle();
      if (fin) j++;
      if (i == 3) held = out_result;
    end
    check("stall_accepts", 64'(j), 64'(LAT));
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_stable", 64'(out_result), 64'(held));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (j < 4) drive(1'b1, 32'h1000 + 32'(j), 32'h0100_0000 * 32'(j + 1), 1'b0);
      else drive(1'b0, '0, '0, 1'b0);
      cycle();
      check("release_nogap", 64'(fout), 64'd1);
      if (fin) j++;
    end
    drain(10);

    // reset with beats in flight
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1); cycle();
    drive(1'b1, 32'hCAFE_F00D, 32'h8765_4321, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(out_result), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("no_stale", 64'(out_valid), 64'd0);
    end
    chk_lat = 1'b1;
    drive(1'b1, 32'h0F0F_F0F0, 32'h7FFF_8001, 1'b1); cycle();
    drain(10);

`ifdef CSA_RESOLVE_FOLD_EN
    drive(1'b1, 32'h0001_FFFF, 32'h0000_0000, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0);
    repeat (LAT - 1) cycle();
    check("fold_a", 64'(out_fold), 64'h0001);
    drain(10);
    drive(1'b1, 32'h0001_0000, 32'h7FFF_8000, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0);
    repeat (LAT - 1) cycle();
    check("fold_b_hi", 64'(out_hi), 64'd1);
    check("fold_b", 64'(out_fold), 64'h0001);
    drain(10);
`endif
    chk_lat = 1'b0;

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 3))
        0: begin in_sum = 32'hFFFF_FFFF; in_carry = 32'hFFFF_FFFF; end
        1: begin in_sum = $urandom; in_carry = 32'h0000_FFFF & $urandom; end
        default: begin in_sum = $urandom; in_carry = $urandom; end
      endcase
      in_last = $urandom_range(0, 1) == 1;
      cycle();
    end
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
